// File: rtl/pc_rx_word_stream.sv
// pc_rx_word_stream: UART byte receiver, byte-to-word deserialiser and FWFT word FIFO.
//   i_clock               system clock
//   i_reset               synchronous active-high reset
//   i_rx_serial           asynchronous UART line, idle high
//   i_read_next_word_cmd  1-cycle pop of the head word
//   o_fifo_output_word    head word, valid whenever the FIFO is not empty
//   o_fifo_is_empty_sig   FIFO empty
//   o_fifo_is_full_sig    FIFO full
//   o_fifo_fill_level     words stored
//   o_word_recv_sig       pulse per completed word, written or dropped
//   o_framing_error_sig   pulse on a bad stop bit
//   o_resync_sig          pulse when an inter-byte timeout discards a partial word
//   o_overflow_count      saturating count of words dropped on a full FIFO
module pc_rx_word_stream #(
    parameter int CLKS_PER_BIT    = 435,
    parameter int BYTES_PER_WORD  = 4,
    parameter bit MSB_FIRST       = 1'b1,
    parameter int FIFO_DEPTH_LOG2 = 4,
    parameter int TIMEOUT_BITS    = 20
) (
    input  logic                        i_clock,
    input  logic                        i_reset,
    input  logic                        i_rx_serial,
    input  logic                        i_read_next_word_cmd,
    output logic [8*BYTES_PER_WORD-1:0] o_fifo_output_word,
    output logic                        o_fifo_is_empty_sig,
    output logic                        o_fifo_is_full_sig,
    output logic [FIFO_DEPTH_LOG2:0]    o_fifo_fill_level,
    output logic                        o_word_recv_sig,
    output logic                        o_framing_error_sig,
    output logic                        o_resync_sig,
    output logic [15:0]                 o_overflow_count
);
    localparam int W        = 8 * BYTES_PER_WORD;
    localparam int DEPTH    = 2 ** FIFO_DEPTH_LOG2;
    localparam int AW       = FIFO_DEPTH_LOG2;
    localparam int LW       = FIFO_DEPTH_LOG2 + 1;
    localparam int CW       = $clog2(CLKS_PER_BIT);
    localparam int KW       = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int TO_LIMIT = TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW       = $clog2(TO_LIMIT + 2);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HIGH} state_e;

    state_e          state_q;
    logic            sync1_q, sync2_q;
    logic [CW-1:0]   cnt_q;
    logic [2:0]      bit_q;
    logic [7:0]      sh_q;
    logic            byte_valid_q, ferr_q;
    logic [KW-1:0]   k_q;
    logic [TW-1:0]   to_q;
    logic [W-1:0]    asm_q, asm_d;
    logic            word_recv_q, resync_q;
    logic [W-1:0]    mem_q [DEPTH];
    logic [AW-1:0]   wp_q, rp_q;
    logic [LW-1:0]   level_q, level_d;
    logic            full_q, empty_q;
    logic [15:0]     ovf_q;
    logic            rd, wr, drop;

    // Receiver: two-flop synchroniser plus bit-timing FSM; all decisions use sync2_q.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q      <= IDLE;
            sync1_q      <= 1'b1;
            sync2_q      <= 1'b1;
            cnt_q        <= '0;
            bit_q        <= '0;
            sh_q         <= '0;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            sync1_q      <= i_rx_serial;
            sync2_q      <= sync1_q;
            byte_valid_q <= 1'b0;
            ferr_q       <= 1'b0;
            case (state_q)
                IDLE: if (!sync2_q) begin
                    state_q <= START;
                    cnt_q   <= '0;
                end
                START: if (cnt_q == CW'(CLKS_PER_BIT / 2 - 1)) begin
                    // Line back high at mid start bit is a glitch, not a start.
                    cnt_q   <= '0;
                    bit_q   <= '0;
                    state_q <= sync2_q ? IDLE : DATA;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                DATA: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_q <= '0;
                    sh_q  <= {sync2_q, sh_q[7:1]};
                    bit_q <= bit_q + 3'd1;
                    if (bit_q == 3'd7) state_q <= STOP;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                STOP: if (cnt_q == CW'(CLKS_PER_BIT - 1)) begin
                    cnt_q        <= '0;
                    byte_valid_q <= sync2_q;
                    ferr_q       <= !sync2_q;
                    // A low stop bit may be a break; wait for the line to recover.
                    state_q      <= sync2_q ? IDLE : WAIT_HIGH;
                end else begin
                    cnt_q <= cnt_q + CW'(1);
                end
                WAIT_HIGH: if (sync2_q) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    // Place the received byte into the lane selected by the byte index and byte order.
    always_comb begin
        asm_d = asm_q;
        for (int j = 0; j < BYTES_PER_WORD; j++)
            if (k_q == KW'(MSB_FIRST ? BYTES_PER_WORD - 1 - j : j)) asm_d[8*j +: 8] = sh_q;
    end

    // Deserialiser and inter-byte timeout. The timeout only counts receiver-idle
    // clocks mid-word, so back-to-back bytes never trip it.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            k_q         <= '0;
            to_q        <= '0;
            asm_q       <= '0;
            word_recv_q <= 1'b0;
            resync_q    <= 1'b0;
        end else begin
            word_recv_q <= 1'b0;
            resync_q    <= 1'b0;
            if (ferr_q) begin
                k_q  <= '0;
                to_q <= '0;
            end else if (byte_valid_q) begin
                asm_q <= asm_d;
                to_q  <= '0;
                if (k_q == KW'(BYTES_PER_WORD - 1)) begin
                    k_q         <= '0;
                    word_recv_q <= 1'b1;
                end else begin
                    k_q <= k_q + KW'(1);
                end
            end else if (TIMEOUT_BITS != 0 && k_q != '0 && state_q == IDLE) begin
                if (to_q == TW'(TO_LIMIT - 1)) begin
                    k_q      <= '0;
                    to_q     <= '0;
                    resync_q <= 1'b1;
                end else begin
                    to_q <= to_q + TW'(1);
                end
            end else begin
                to_q <= '0;
            end
        end
    end

    // FIFO control: a read on empty is ignored; a write on full succeeds only with a read.
    always_comb begin
        rd      = i_read_next_word_cmd && !empty_q;
        wr      = word_recv_q && (!full_q || rd);
        drop    = word_recv_q && full_q && !rd;
        level_d = level_q + LW'(wr) - LW'(rd);
    end

    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            wp_q    <= '0;
            rp_q    <= '0;
            level_q <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
            ovf_q   <= '0;
        end else begin
            if (wr) wp_q <= wp_q + AW'(1);
            if (rd) rp_q <= rp_q + AW'(1);
            level_q <= level_d;
            full_q  <= level_d == LW'(DEPTH);
            empty_q <= level_d == '0;
            if (drop && ovf_q != 16'hFFFF) ovf_q <= ovf_q + 16'd1;
        end
    end

    always_ff @(posedge i_clock) begin
        if (wr) mem_q[wp_q] <= asm_q;
    end

    assign o_fifo_output_word  = empty_q ? '0 : mem_q[rp_q];
    assign o_fifo_is_empty_sig = empty_q;
    assign o_fifo_is_full_sig  = full_q;
    assign o_fifo_fill_level   = level_q;
    assign o_word_recv_sig     = word_recv_q;
    assign o_framing_error_sig = ferr_q;
    assign o_resync_sig        = resync_q;
    assign o_overflow_count    = ovf_q;
endmodule

// File: tb/tb_pc_rx_word_stream.sv
// tb_pc_rx_word_stream: directed bench for pc_rx_word_stream, one instance per byte order.
module tb_pc_rx_word_stream;
    logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd = 1'b0;
    logic [31:0] wa, wb;
    logic ea, eb, fa, fb, wra, wrb, fea, feb, rsa, rsb;
    logic [2:0] la, lb;
    logic [15:0] oa, ob;
    logic got, e_at, e_after;
    int checks = 0, errors = 0;
    int nwr_a = 0, nfe_a = 0, nrs_a = 0, nwr_b = 0, nfe_b = 0, nrs_b = 0;

    always #5 clk = ~clk;

    pc_rx_word_stream #(.CLKS_PER_BIT(8), .BYTES_PER_WORD(4), .MSB_FIRST(1'b1),
        .FIFO_DEPTH_LOG2(2), .TIMEOUT_BITS(2)) dut_a (
        .i_clock(clk), .i_reset(rst), .i_rx_serial(rx), .i_read_next_word_cmd(rd),
        .o_fifo_output_word(wa), .o_fifo_is_empty_sig(ea), .o_fifo_is_full_sig(fa),
        .o_fifo_fill_level(la), .o_word_recv_sig(wra), .o_framing_error_sig(fea),
        .o_resync_sig(rsa), .o_overflow_count(oa));

    pc_rx_word_stream #(.CLKS_PER_BIT(8), .BYTES_PER_WORD(4), .MSB_FIRST(1'b0),
        .FIFO_DEPTH_LOG2(2), .TIMEOUT_BITS(2)) dut_b (
        .i_clock(clk), .i_reset(rst), .i_rx_serial(rx), .i_read_next_word_cmd(rd),
        .o_fifo_output_word(wb), .o_fifo_is_empty_sig(eb), .o_fifo_is_full_sig(fb),
        .o_fifo_fill_level(lb), .o_word_recv_sig(wrb), .o_framing_error_sig(feb),
        .o_resync_sig(rsb), .o_overflow_count(ob));

    always @(posedge clk) begin
        if (!rst) begin
            nwr_a <= nwr_a + int'(wra);
            nfe_a <= nfe_a + int'(fea);
            nrs_a <= nrs_a + int'(rsa);
            nwr_b <= nwr_b + int'(wrb);
            nfe_b <= nfe_b + int'(feb);
            nrs_b <= nrs_b + int'(rsb);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] wd(input int n);
        logic [7:0] b;
        b = 8'(16 * n);
        return {b, b + 8'd1, b + 8'd2, b + 8'd3};
    endfunction

    function automatic logic [31:0] sw(input logic [31:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic stop);
        @(negedge clk) rx = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (8) @(negedge clk);
        end
        rx = stop;
        repeat (8) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 3; i >= 0; i--) send_byte(w[8*i +: 8], 1'b1);
        repeat (3) @(negedge clk);
    endtask

    // Sends a word while watching for the o_word_recv_sig cycle; optionally pops in that cycle.
    task automatic send_word_poll(input logic [31:0] w, input logic pop_on_recv);
        for (int i = 3; i >= 1; i--) send_byte(w[8*i +: 8], 1'b1);
        got = 1'b0;
        fork
            send_byte(w[7:0], 1'b1);
            begin
                for (int i = 0; i < 200 && !got; i++) begin
                    @(posedge clk);
                    #1;
                    if (wra) got = 1'b1;
                end
                e_at = ea;
                if (got && pop_on_recv) rd = 1'b1;
                @(posedge clk);
                #1;
                rd = 1'b0;
                e_after = ea;
            end
        join
        repeat (3) @(negedge clk);
    endtask

    task automatic pop();
        @(negedge clk) rd = 1'b1;
        @(negedge clk) rd = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_empty", ea, 1);
        chk("rst_full", fa, 0);
        chk("rst_level", la, 0);
        chk("rst_word", wa, 0);
        chk("rst_ovf", oa, 0);
        chk("rst_pulses", {wra, fea, rsa}, 0);
        chk("rst_empty_b", eb, 1);

        rx = 1'b0;
        repeat (2) @(negedge clk);
        rx = 1'b1;
        repeat (20) @(negedge clk);
        chk("glitch_empty", ea, 1);
        chk("glitch_ferr", nfe_a, 0);
        chk("glitch_words", nwr_a, 0);

        send_word_poll(32'hDEADBEEF, 1'b0);
        chk("w1_recv_seen", got, 1);
        chk("w1_empty_at_recv", e_at, 1);
        chk("w1_empty_after", e_after, 0);
        chk("w1_word_msb", wa, 32'hDEADBEEF);
        chk("w1_word_lsb", wb, 32'hEFBEADDE);
        chk("w1_level", la, 1);
        chk("w1_recv_count", nwr_a, 1);
        pop();
        chk("w1_pop_empty", ea, 1);
        chk("w1_pop_level", la, 0);

        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        send_byte(8'h55, 1'b0);
        repeat (10) @(negedge clk);
        chk("fe_count", nfe_a, 1);
        chk("fe_no_word", ea, 1);
        send_word(32'h01020304);
        chk("fe_word", wa, 32'h01020304);
        chk("fe_word_b", wb, 32'h04030201);
        chk("fe_level", la, 1);
        chk("fe_recv_count", nwr_a, 2);
        pop();

        send_byte(8'hAA, 1'b1);
        send_byte(8'hBB, 1'b1);
        repeat (30) @(negedge clk);
        chk("to_resync", nrs_a, 1);
        chk("to_no_word", nwr_a, 2);
        send_word(32'h01020304);
        chk("to_word", wa, 32'h01020304);
        chk("to_word_b", wb, 32'h04030201);
        chk("to_level", la, 1);
        chk("to_resync_once", nrs_a, 1);
        pop();

        for (int n = 1; n <= 6; n++) send_word(wd(n));
        chk("ov_full", fa, 1);
        chk("ov_level", la, 4);
        chk("ov_count", oa, 2);
        chk("ov_count_b", ob, 2);
        chk("ov_recv_count", nwr_a, 9);
        for (int n = 1; n <= 4; n++) begin
            chk("ov_head", wa, wd(n));
            chk("ov_head_b", wb, sw(wd(n)));
            pop();
        end
        chk("ov_drained_empty", ea, 1);
        chk("ov_drained_level", la, 0);
        chk("ov_drained_full", fa, 0);
        pop();
        chk("ov_extra_level", la, 0);
        chk("ov_extra_empty", ea, 1);

        for (int n = 7; n <= 10; n++) send_word(wd(n));
        chk("rw_full_before", fa, 1);
        send_word_poll(wd(11), 1'b1);
        chk("rw_recv_seen", got, 1);
        chk("rw_level", la, 4);
        chk("rw_full", fa, 1);
        chk("rw_ovf", oa, 2);
        chk("rw_head", wa, wd(8));
        chk("rw_full_b", fb, 1);

        @(negedge clk) rx = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        rx = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("mr_empty", ea, 1);
        chk("mr_level", la, 0);
        chk("mr_full", fa, 0);
        chk("mr_ovf", oa, 0);
        chk("mr_word", wa, 0);
        chk("mr_level_b", lb, 0);
        repeat (10) @(negedge clk);
        send_word(32'hCAFEF00D);
        chk("mr_new_word", wa, 32'hCAFEF00D);
        chk("mr_new_word_b", wb, 32'h0DF0FECA);
        chk("mr_new_level", la, 1);
        chk("end_recv_a", nwr_a, 15);
        chk("end_recv_b", nwr_b, 15);
        chk("end_ferr_a", nfe_a, 1);
        chk("end_ferr_b", nfe_b, 1);
        chk("end_resync_b", nrs_b, 1);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
